// File: rtl/uart_echo_fifo.sv
// -----------------------------------------------------------------------------
// uart_echo_fifo
//
// Byte buffer between the UART receiver strobe (rxuart/rxuartlite) and the
// UART transmitter write port (txuart/txuartlite) in the smart-echo path. It
// absorbs a small rate mismatch between a slightly fast receiver and the
// transmitter. Bytes are dropped only when the buffer is full, and the drop is
// recorded in a sticky overflow flag.
//
// Structure:
//   - Circular FIFO of 2^LGFLEN x 8 bits. Pointers and the fill count are
//     LGFLEN+1 bits wide so that "full" and "empty" are distinct.
//   - A one-entry output register (o_tx_stb/o_tx_data) is loaded from FIFO
//     storage through a registered read. It holds steady until the
//     transmitter accepts it (o_tx_stb && !i_tx_busy).
//
// Optional feature (compile-time macro ECHO_CRLF_EN):
//   When it is defined, an accepted 8'h0D is followed by an inserted 8'h0A.
//   When it is undefined, bytes pass through verbatim and the LF state is
//   absent.
//
// Parameters:
//   LGFLEN          log2 of FIFO depth (legal 2..10, default 4 -> 16 entries)
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_rx_stb        one-cycle strobe: i_rx_data holds a received byte
//   i_rx_data[7:0]  received byte
//   o_tx_stb        byte valid toward the transmitter (txuart i_wr)
//   o_tx_data[7:0]  byte to transmit (txuart i_data)
//   i_tx_busy       transmitter busy (txuart o_busy)
//   o_fill          FIFO entry count, excluding the output register
//   o_overflow      sticky: a byte was dropped because the FIFO was full
//   i_clr_overflow  synchronous clear of o_overflow (a new drop wins)
// -----------------------------------------------------------------------------
module uart_echo_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_stb,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_overflow,
  input  logic              i_clr_overflow
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] ONE      = {{LGFLEN{1'b0}}, 1'b1};

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  // Output-stage state. ST_LF exists only when CR->CRLF expansion is built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef ECHO_CRLF_EN
    , ST_LF = 2'd2
`endif
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;

  logic [LGFLEN-1:0] wr_addr;
  logic [LGFLEN-1:0] rd_addr;

  logic full;
  logic empty;
  logic accept;
  logic lf_due;
  logic out_free;
  logic pop;
  logic push;
  logic drop;

  assign wr_addr = wr_ptr[LGFLEN-1:0];
  assign rd_addr = rd_ptr[LGFLEN-1:0];

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    full     = (o_fill == FULL_CNT);
    empty    = (o_fill == '0);
    accept   = o_tx_stb && !i_tx_busy;
    lf_due   = 1'b0;
`ifdef ECHO_CRLF_EN
    // A CR leaving the DATA state must be followed by an inserted LF, so the
    // output register is not free for a FIFO pop in that cycle.
    lf_due   = accept && (state == ST_DATA) && (o_tx_data == CR_BYTE);
`endif
    // The output register can take a new byte when it is empty, or when its
    // current byte leaves this cycle and no LF has to follow it.
    out_free = (state == ST_IDLE) || (accept && !lf_due);
    pop      = !empty && out_free;
    // A full FIFO still accepts a byte if a slot frees up in the same cycle.
    push     = i_rx_stb && (!full || pop);
    drop     = i_rx_stb && !push;
  end

  // NOTE: the storage array has no reset. Its contents are meaningless until
  // written, and the pointers and fill count (which are reset) decide what is
  // valid. This keeps the array mappable onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_addr] <= i_rx_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then sees the pre-edge values of the others, so a pop and a push to the
  // same full slot read the old byte before it is overwritten.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      o_tx_stb   <= 1'b0;
      o_tx_data  <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_fill     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
      end

      case ({push, pop})
        2'b10:   o_fill <= o_fill + ONE;
        2'b01:   o_fill <= o_fill - ONE;
        default: o_fill <= o_fill;
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        o_overflow <= 1'b0;
      end

      // Output stage. A pop always wins: it reloads the register from storage.
      // Otherwise an accept either inserts the LF after a CR or empties the
      // stage. Without an accept, stb and data hold.
      if (pop) begin
        state     <= ST_DATA;
        o_tx_stb  <= 1'b1;
        o_tx_data <= mem[rd_addr];
      end else if (accept) begin
`ifdef ECHO_CRLF_EN
        if (lf_due) begin
          state     <= ST_LF;
          o_tx_stb  <= 1'b1;
          o_tx_data <= LF_BYTE;
        end else begin
          state    <= ST_IDLE;
          o_tx_stb <= 1'b0;
        end
`else
        state    <= ST_IDLE;
        o_tx_stb <= 1'b0;
`endif
      end
    end
  end

endmodule
